// File: rtl/zilla_gpr_bank_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// zilla_gpr_bank_if : read/write/loader/debug bus for the Zilla GPR bank
// Revision 1.0
// ---------------------------------------------------------------------------
interface zilla_gpr_bank_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int NUM_RD_PORTS   = 2
);
  logic [NUM_RD_PORTS*GPR_ADDR_WIDTH-1:0] rd_addr_i;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0]     rd_data_o;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0]     rd_data_q_o;
  logic                                   wr_en_i;
  logic [GPR_ADDR_WIDTH-1:0]              wr_addr_i;
  logic [DATA_WIDTH-1:0]                  wr_data_i;
  logic                                   uart_wr_valid_i;
  logic [GPR_ADDR_WIDTH-1:0]              uart_wr_addr_i;
  logic [DATA_WIDTH-1:0]                  uart_wr_data_i;
  logic                                   hart_reset_i;
  logic                                   dbg_req_i;
  logic                                   dbg_we_i;
  logic [15:0]                            dbg_addr_i;
  logic [DATA_WIDTH-1:0]                  dbg_wdata_i;
  logic                                   dbg_ack_o;
  logic                                   dbg_err_o;
  logic [DATA_WIDTH-1:0]                  dbg_rdata_o;
  logic                                   clr_busy_o;
  logic                                   wr_drop_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
    output uart_wr_valid_i, uart_wr_addr_i, uart_wr_data_i, hart_reset_i,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  rd_data_o, rd_data_q_o, dbg_ack_o, dbg_err_o, dbg_rdata_o,
    input  clr_busy_o, wr_drop_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
    input  uart_wr_valid_i, uart_wr_addr_i, uart_wr_data_i, hart_reset_i,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output rd_data_o, rd_data_q_o, dbg_ack_o, dbg_err_o, dbg_rdata_o,
    output clr_busy_o, wr_drop_o
  );
endinterface
`default_nettype wire

// File: rtl/zilla_gpr_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// zilla_gpr_bank : GPR file with clear sequencer, 3-source write arbiter,
//                  optional write bypass and req/ack debug channel. Rev 1.0
// ---------------------------------------------------------------------------
module zilla_gpr_bank #(
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int NUM_RD_PORTS   = 2,
  parameter int BYPASS         = 1
) (
  input  logic             reg_clk,
  input  logic             reg_rst,
  zilla_gpr_bank_if.slave  bus
);
  localparam int DW    = DATA_WIDTH;
  localparam int AW    = GPR_ADDR_WIDTH;
  localparam int DEPTH = 2 ** GPR_ADDR_WIDTH;

  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} main_state_t;
  typedef enum logic [0:0] {IDLE = 1'b0, ACK = 1'b1} dbg_state_t;

  main_state_t     state;
  dbg_state_t      dbg_state;
  logic [AW-1:0]   clr_ptr;
  logic [DW-1:0]   regfile [DEPTH];

  logic            run;
  logic [11:0]     dbg_hi;
  logic            dbg_legal;
  logic [AW-1:0]   dbg_idx;
  logic            dbg_accept;
  logic            dbg_wr;
  logic            uart_wr;
  logic            core_wr;
  logic            win_en;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;
  logic            lost;
  logic            unused_dbg_addr;

  assign run             = (state == RUN);
  assign dbg_hi          = bus.dbg_addr_i[11:0] >> GPR_ADDR_WIDTH;
  assign dbg_legal       = bus.dbg_addr_i[12] && (dbg_hi == 12'd0);
  assign dbg_idx         = bus.dbg_addr_i[AW-1:0];
  assign dbg_accept      = run && (dbg_state == IDLE) && bus.dbg_req_i;
  assign dbg_wr          = dbg_accept && bus.dbg_we_i && dbg_legal;
  assign uart_wr         = run && bus.uart_wr_valid_i;
  assign core_wr         = run && bus.wr_en_i;
  assign unused_dbg_addr = ^bus.dbg_addr_i[15:13];
  assign bus.clr_busy_o  = (state == CLEAR);

  // Priority: debug > UART loader > core; every asserted loser counts as a drop.
  always_comb begin
    win_en   = 1'b0;
    win_addr = '0;
    win_data = '0;
    lost     = 1'b0;
    if (dbg_wr) begin
      win_en   = 1'b1;
      win_addr = dbg_idx;
      win_data = bus.dbg_wdata_i;
      lost     = uart_wr || core_wr;
    end else if (uart_wr) begin
      win_en   = 1'b1;
      win_addr = bus.uart_wr_addr_i;
      win_data = bus.uart_wr_data_i;
      lost     = core_wr;
    end else if (core_wr) begin
      win_en   = 1'b1;
      win_addr = bus.wr_addr_i;
      win_data = bus.wr_data_i;
    end
  end

  always_ff @(posedge reg_clk) begin
    if (!reg_rst) begin
      if (!run) begin
        regfile[clr_ptr] <= '0;
      end else if (win_en && (win_addr != '0)) begin
        regfile[win_addr] <= win_data;
      end
    end
  end

  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      state         <= CLEAR;
      clr_ptr       <= '0;
      bus.wr_drop_o <= 1'b0;
    end else begin
      bus.wr_drop_o <= lost;
      if (bus.hart_reset_i) begin
        state   <= CLEAR;
        clr_ptr <= '0;
      end else if (state == CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
        if (clr_ptr == '1) begin
          state <= RUN;
        end
      end
    end
  end

  // The ack is allowed to finish even if a clear starts while it is pending.
  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      dbg_state       <= IDLE;
      bus.dbg_ack_o   <= 1'b0;
      bus.dbg_err_o   <= 1'b0;
      bus.dbg_rdata_o <= '0;
    end else begin
      case (dbg_state)
        IDLE: begin
          if (dbg_accept) begin
            dbg_state       <= ACK;
            bus.dbg_ack_o   <= 1'b1;
            bus.dbg_err_o   <= !dbg_legal;
            bus.dbg_rdata_o <= (dbg_legal && !bus.dbg_we_i) ? regfile[dbg_idx] : '0;
          end
        end
        ACK: begin
          dbg_state       <= IDLE;
          bus.dbg_ack_o   <= 1'b0;
          bus.dbg_err_o   <= 1'b0;
          bus.dbg_rdata_o <= '0;
        end
        default: dbg_state <= IDLE;
      endcase
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
      logic [AW-1:0] addr;
      logic [DW-1:0] word;

      assign addr = bus.rd_addr_i[k*AW +: AW];

      always_comb begin
        word = '0;
        if (run && (addr != '0)) begin
          if ((BYPASS != 0) && win_en && (win_addr == addr)) begin
            word = win_data;
          end else begin
            word = regfile[addr];
          end
        end
      end

      assign bus.rd_data_o[k*DW +: DW] = word;
    end
  endgenerate

  always_ff @(posedge reg_clk) begin
    if (reg_rst) begin
      bus.rd_data_q_o <= '0;
    end else begin
      bus.rd_data_q_o <= bus.rd_data_o;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_zilla_gpr_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_zilla_gpr_bank : directed vector bench, RV32I/bypass and RV32E/no-bypass
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_zilla_gpr_bank;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  zilla_gpr_bank_if #(.DATA_WIDTH(32), .GPR_ADDR_WIDTH(5), .NUM_RD_PORTS(2)) a_if ();
  zilla_gpr_bank_if #(.DATA_WIDTH(32), .GPR_ADDR_WIDTH(4), .NUM_RD_PORTS(3)) b_if ();

  zilla_gpr_bank #(.DATA_WIDTH(32), .GPR_ADDR_WIDTH(5), .NUM_RD_PORTS(2), .BYPASS(1)) dut_a (
    .reg_clk (clk),
    .reg_rst (rst_a),
    .bus     (a_if.slave)
  );

  zilla_gpr_bank #(.DATA_WIDTH(32), .GPR_ADDR_WIDTH(4), .NUM_RD_PORTS(3), .BYPASS(0)) dut_b (
    .reg_clk (clk),
    .reg_rst (rst_b),
    .bus     (b_if.slave)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        uv;
    logic [4:0]  ua;
    logic [31:0] ud;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        edrop;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_if.wr_en_i = 1'b0;         a_if.wr_addr_i = '0;      a_if.wr_data_i = '0;
    a_if.uart_wr_valid_i = 1'b0; a_if.uart_wr_addr_i = '0; a_if.uart_wr_data_i = '0;
    a_if.hart_reset_i = 1'b0;    a_if.dbg_req_i = 1'b0;    a_if.dbg_we_i = 1'b0;
    a_if.dbg_addr_i = '0;        a_if.dbg_wdata_i = '0;
  endtask

  task automatic idle_b();
    b_if.wr_en_i = 1'b0;         b_if.wr_addr_i = '0;      b_if.wr_data_i = '0;
    b_if.uart_wr_valid_i = 1'b0; b_if.uart_wr_addr_i = '0; b_if.uart_wr_data_i = '0;
    b_if.hart_reset_i = 1'b0;    b_if.dbg_req_i = 1'b0;    b_if.dbg_we_i = 1'b0;
    b_if.dbg_addr_i = '0;        b_if.dbg_wdata_i = '0;
  endtask

  // Cycles spent with clr_busy_o high, bounded so a stuck clear cannot hang the run.
  task automatic clear_len(input bit sel, output int n, output bit ack_seen);
    n = 0;
    ack_seen = 1'b0;
    while ((sel ? b_if.clr_busy_o : a_if.clr_busy_o) && n < 100) begin
      if (sel ? b_if.dbg_ack_o : a_if.dbg_ack_o) ack_seen = 1'b1;
      n++;
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;

    vt[0] = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0, 32'h0,        5'd5,  5'd0,  32'h12345678, 32'h0,        1'b0};
    vt[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        5'd0,  5'd5,  32'h0,        32'h12345678, 1'b0};
    vt[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd0,  5'd5,  32'h0,        32'h12345678, 1'b0};
    vt[3] = '{1'b1, 5'd6,  32'h11,       1'b1, 5'd6, 32'h0BADF00D, 5'd6,  5'd6,  32'h0BADF00D, 32'h0BADF00D, 1'b1};
    vt[4] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd6,  5'd10, 32'h0BADF00D, 32'h0,        1'b0};
    vt[5] = '{1'b1, 5'd10, 32'h55,       1'b0, 5'd0, 32'h0,        5'd10, 5'd1,  32'h55,       32'h0,        1'b0};
    vt[6] = '{1'b1, 5'd1,  32'hA5A5A5A5, 1'b1, 5'd2, 32'h5A5A5A5A, 5'd1,  5'd2,  32'h0,        32'h5A5A5A5A, 1'b1};
    vt[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,        5'd1,  5'd2,  32'h0,        32'h5A5A5A5A, 1'b0};

    rst_a = 1'b1;
    rst_b = 1'b1;
    idle_a();
    idle_b();
    a_if.rd_addr_i = '0;
    b_if.rd_addr_i = '0;
    tick();
    tick();

    chk("rst_clr_busy", 32'(a_if.clr_busy_o), 32'd1);
    chk("rst_ack",      32'(a_if.dbg_ack_o),  32'd0);
    chk("rst_err",      32'(a_if.dbg_err_o),  32'd0);
    chk("rst_rdata",    a_if.dbg_rdata_o,     32'd0);
    chk("rst_drop",     32'(a_if.wr_drop_o),  32'd0);
    chk("rst_rdq",      a_if.rd_data_q_o[31:0] | a_if.rd_data_q_o[63:32], 32'd0);

    rst_a = 1'b0;
    clear_len(1'b0, n, seen);
    chk("clr_len_first", 32'(n), 32'd32);

    // Preload garbage, then reset again and confirm it is wiped.
    for (int r = 3; r <= 5; r++) begin
      a_if.wr_en_i = 1'b1; a_if.wr_addr_i = 5'(r); a_if.wr_data_i = 32'hDEADBEEF;
      tick();
    end
    idle_a();
    a_if.rd_addr_i = {5'd0, 5'd4};
    @(negedge clk);
    chk("preload_x4", a_if.rd_data_o[31:0], 32'hDEADBEEF);

    rst_a = 1'b1;
    tick(); tick(); tick();
    rst_a = 1'b0;
    a_if.wr_en_i = 1'b1; a_if.wr_addr_i = 5'd9; a_if.wr_data_i = 32'h99;
    a_if.uart_wr_valid_i = 1'b1; a_if.uart_wr_addr_i = 5'd8; a_if.uart_wr_data_i = 32'h88;
    @(negedge clk);
    chk("clear_rd_forced0", a_if.rd_data_o[31:0], 32'd0);
    tick();
    chk("clear_no_drop", 32'(a_if.wr_drop_o), 32'd0);
    idle_a();
    clear_len(1'b0, n, seen);
    chk("clr_len_held_rst", 32'(n + 1), 32'd32);

    for (int r = 0; r < 32; r++) begin
      a_if.rd_addr_i = {5'(31 - r), 5'(r)};
      @(negedge clk);
      chk($sformatf("cleared_p0_x%0d", r), a_if.rd_data_o[31:0],  32'd0);
      chk($sformatf("cleared_p1_x%0d", 31 - r), a_if.rd_data_o[63:32], 32'd0);
    end
    tick();

    for (int i = 0; i < 8; i++) begin
      a_if.wr_en_i = vt[i].we; a_if.wr_addr_i = vt[i].wa; a_if.wr_data_i = vt[i].wd;
      a_if.uart_wr_valid_i = vt[i].uv; a_if.uart_wr_addr_i = vt[i].ua;
      a_if.uart_wr_data_i = vt[i].ud;
      a_if.rd_addr_i = {vt[i].ra1, vt[i].ra0};
      @(negedge clk);
      chk($sformatf("v%0d_rd0", i), a_if.rd_data_o[31:0],  vt[i].e0);
      chk($sformatf("v%0d_rd1", i), a_if.rd_data_o[63:32], vt[i].e1);
      tick();
      chk($sformatf("v%0d_rdq0", i), a_if.rd_data_q_o[31:0],  vt[i].e0);
      chk($sformatf("v%0d_rdq1", i), a_if.rd_data_q_o[63:32], vt[i].e1);
      chk($sformatf("v%0d_drop", i), 32'(a_if.wr_drop_o), 32'(vt[i].edrop));
    end
    idle_a();

    // Three writers at once: debug x7 beats UART x7 and core x9.
    a_if.wr_en_i = 1'b1; a_if.wr_addr_i = 5'd9; a_if.wr_data_i = 32'hC;
    a_if.uart_wr_valid_i = 1'b1; a_if.uart_wr_addr_i = 5'd7; a_if.uart_wr_data_i = 32'hB;
    a_if.dbg_req_i = 1'b1; a_if.dbg_we_i = 1'b1; a_if.dbg_addr_i = 16'h1007;
    a_if.dbg_wdata_i = 32'hA;
    a_if.rd_addr_i = {5'd9, 5'd7};
    @(negedge clk);
    chk("arb_bypass_x7", a_if.rd_data_o[31:0],  32'hA);
    chk("arb_x9_old",    a_if.rd_data_o[63:32], 32'h0);
    tick();
    chk("arb_drop",      32'(a_if.wr_drop_o), 32'd1);
    chk("arb_ack",       32'(a_if.dbg_ack_o), 32'd1);
    chk("arb_err",       32'(a_if.dbg_err_o), 32'd0);
    chk("arb_rdata",     a_if.dbg_rdata_o,    32'd0);
    idle_a();
    @(negedge clk);
    chk("arb_x7_stored", a_if.rd_data_o[31:0],  32'hA);
    chk("arb_x9_kept",   a_if.rd_data_o[63:32], 32'h0);
    tick();
    chk("ack_one_cycle", 32'(a_if.dbg_ack_o), 32'd0);

    // Debug read of x10 racing a core write to x10 returns the old value.
    a_if.dbg_req_i = 1'b1; a_if.dbg_we_i = 1'b0; a_if.dbg_addr_i = 16'h100A;
    a_if.wr_en_i = 1'b1; a_if.wr_addr_i = 5'd10; a_if.wr_data_i = 32'h99;
    @(negedge clk);
    chk("dbg_no_early_ack", 32'(a_if.dbg_ack_o), 32'd0);
    tick();
    chk("dbg_rd_ack",   32'(a_if.dbg_ack_o), 32'd1);
    chk("dbg_rd_err",   32'(a_if.dbg_err_o), 32'd0);
    chk("dbg_rd_old",   a_if.dbg_rdata_o,    32'h55);
    idle_a();
    a_if.rd_addr_i = {5'd0, 5'd10};
    @(negedge clk);
    chk("x10_new", a_if.rd_data_o[31:0], 32'h99);
    tick();
    chk("dbg_rdata_clr", a_if.dbg_rdata_o, 32'd0);

    // Illegal debug addresses: GPR bit missing, and stray bit above the index.
    a_if.dbg_req_i = 1'b1; a_if.dbg_we_i = 1'b1; a_if.dbg_addr_i = 16'h0005;
    a_if.dbg_wdata_i = 32'h77;
    tick();
    chk("ill0_ack",   32'(a_if.dbg_ack_o), 32'd1);
    chk("ill0_err",   32'(a_if.dbg_err_o), 32'd1);
    chk("ill0_rdata", a_if.dbg_rdata_o,    32'd0);
    idle_a();
    tick();
    a_if.dbg_req_i = 1'b1; a_if.dbg_we_i = 1'b1; a_if.dbg_addr_i = 16'h1025;
    a_if.dbg_wdata_i = 32'h66;
    tick();
    chk("ill1_err", 32'(a_if.dbg_err_o), 32'd1);
    idle_a();
    a_if.rd_addr_i = {5'd0, 5'd5};
    @(negedge clk);
    chk("ill_no_store", a_if.rd_data_o[31:0], 32'h12345678);
    tick();

    // Held request: one access every second cycle.
    a_if.dbg_req_i = 1'b1; a_if.dbg_we_i = 1'b0; a_if.dbg_addr_i = 16'h1005;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("thru_ack%0d", i), 32'(a_if.dbg_ack_o), 32'((i % 2) == 0));
      if (i == 0) chk("thru_rdata", a_if.dbg_rdata_o, 32'h12345678);
    end
    idle_a();

    // hart_reset with a pending debug request.
    a_if.hart_reset_i = 1'b1;
    tick();
    a_if.hart_reset_i = 1'b0;
    a_if.dbg_req_i = 1'b1; a_if.dbg_we_i = 1'b0; a_if.dbg_addr_i = 16'h100A;
    clear_len(1'b0, n, seen);
    chk("hart_clr_len",     32'(n),    32'd32);
    chk("hart_no_ack",      32'(seen), 32'd0);
    chk("hart_ack_not_yet", 32'(a_if.dbg_ack_o), 32'd0);
    tick();
    chk("hart_ack_after",   32'(a_if.dbg_ack_o), 32'd1);
    chk("hart_rdata_clr",   a_if.dbg_rdata_o,    32'd0);
    idle_a();
    tick();

    // RV32E, three read ports, no bypass.
    rst_b = 1'b0;
    clear_len(1'b1, n, seen);
    chk("b_clr_len", 32'(n), 32'd16);
    b_if.wr_en_i = 1'b1; b_if.wr_addr_i = 4'd3; b_if.wr_data_i = 32'h33;
    b_if.rd_addr_i = {4'd0, 4'd0, 4'd3};
    @(negedge clk);
    chk("b_nobypass", b_if.rd_data_o[31:0], 32'd0);
    tick();
    idle_b();
    b_if.uart_wr_valid_i = 1'b1; b_if.uart_wr_addr_i = 4'd7; b_if.uart_wr_data_i = 32'h77;
    b_if.rd_addr_i = {4'd15, 4'd7, 4'd3};
    @(negedge clk);
    chk("b_x3",        b_if.rd_data_o[31:0],  32'h33);
    chk("b_x7_old",    b_if.rd_data_o[63:32], 32'h0);
    tick();
    idle_b();
    b_if.wr_en_i = 1'b1; b_if.wr_addr_i = 4'd15; b_if.wr_data_i = 32'hFF;
    tick();
    idle_b();
    b_if.rd_addr_i = {4'd3, 4'd15, 4'd7};
    @(negedge clk);
    chk("b_p0_x7",  b_if.rd_data_o[31:0],  32'h77);
    chk("b_p1_x15", b_if.rd_data_o[63:32], 32'hFF);
    chk("b_p2_x3",  b_if.rd_data_o[95:64], 32'h33);
    tick();
    chk("b_rdq_p2", b_if.rd_data_q_o[95:64], 32'h33);
    b_if.dbg_req_i = 1'b1; b_if.dbg_we_i = 1'b0; b_if.dbg_addr_i = 16'h1010;
    tick();
    chk("b_ill_ack", 32'(b_if.dbg_ack_o), 32'd1);
    chk("b_ill_err", 32'(b_if.dbg_err_o), 32'd1);
    idle_b();
    tick();
    b_if.dbg_req_i = 1'b1; b_if.dbg_we_i = 1'b0; b_if.dbg_addr_i = 16'h100F;
    tick();
    chk("b_dbg_err",   32'(b_if.dbg_err_o), 32'd0);
    chk("b_dbg_rdata", b_if.dbg_rdata_o,    32'hFF);
    idle_b();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
